cordic_nco_iter: RTL and testbench

- Iterative rotation-mode CORDIC sine/cosine generator with amplitude scaling and an optional internal phase accumulator (NCO mode).
- Generalises the team's fixed 16-bit angle CORDIC:
  - parametrised data, phase and amplitude widths and iteration count;
  - full-circle quadrant folding;
  - valid/ready handshakes on both sides;
  - direct-angle and accumulated-phase modes.
- Sits between the waveform control logic and the DAC/modulator datapath.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_nco_iter_if.sv | 30 +++
 rtl/cordic_quadrant_sat.sv | 29 ++
 rtl/cordic_nco_iter.sv | 110 +++++++++++
 tb/tb_cordic_nco_iter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types, arctangent table and gain constant for the CORDIC NCO.
// Contents: state_t FSM encoding, ATAN_TABLE (atan(2^-i), 2^32 = full circle),
// k_init() returning round(0.6072529 * 2^(dw-1)).
package cordic_pkg;

    typedef enum logic [2:0] {IDLE, ROTATE, FOLD, SCALE, HOLD} state_t;

    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // Pre-scales the start vector so the CORDIC gain lands on unit amplitude.
    function automatic longint k_init(input int dw);
        return (longint'(6072529) * (longint'(1) << (dw - 1)) + longint'(5000000)) / longint'(10000000);
    endfunction

endpackage

// File: rtl/cordic_nco_iter_if.sv
// cordic_nco_iter_if: request/result handshake bundle for cordic_nco_iter.
// Request side: in_valid/in_ready, in_mode, in_phase, in_amp, phase_clr.
// Result side: out_valid/out_ready, cos_out, sin_out, phase_acc.
interface cordic_nco_iter_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int AMP_WIDTH   = 16
);
    logic                                in_valid;
    logic                                in_ready;
    logic                                in_mode;
    logic [PHASE_WIDTH-1:0]              in_phase;
    logic [AMP_WIDTH-1:0]                in_amp;
    logic                                phase_clr;
    logic                                out_valid;
    logic                                out_ready;
    logic signed [DATA_WIDTH+AMP_WIDTH-1:0] cos_out;
    logic signed [DATA_WIDTH+AMP_WIDTH-1:0] sin_out;
    logic [PHASE_WIDTH-1:0]              phase_acc;

    modport master (
        output in_valid, in_mode, in_phase, in_amp, phase_clr, out_ready,
        input  in_ready, out_valid, cos_out, sin_out, phase_acc
    );

    modport slave (
        input  in_valid, in_mode, in_phase, in_amp, phase_clr, out_ready,
        output in_ready, out_valid, cos_out, sin_out, phase_acc
    );
endinterface

// File: rtl/cordic_quadrant_sat.sv
// cordic_quadrant_sat: maps the first-quadrant CORDIC vector back to the full circle and saturates.
// Ports: i_x/i_y first-quadrant vector, i_q quadrant, o_c/o_s saturated cos/sin.
module cordic_quadrant_sat #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH+1:0] i_x,
    input  logic signed [DATA_WIDTH+1:0] i_y,
    input  logic [1:0]                   i_q,
    output logic signed [DATA_WIDTH-1:0] o_c,
    output logic signed [DATA_WIDTH-1:0] o_s
);
    localparam int DW = DATA_WIDTH;
    localparam logic signed [DW+1:0] MAX_W = (DW+2)'((1 << (DW - 1)) - 1);
    localparam logic signed [DW-1:0] MAX_N = DW'((1 << (DW - 1)) - 1);

    logic signed [DW+1:0] w_c, w_s;

    // Symmetric clamp keeps -cos(x) == cos(x+180) bit-exact at full scale.
    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        return v > MAX_W ? MAX_N : (v < -MAX_W ? -MAX_N : v[DW-1:0]);
    endfunction

    always_comb begin
        w_c = i_q == 2'd0 ? i_x : (i_q == 2'd1 ? -i_y : (i_q == 2'd2 ? -i_x : i_y));
        w_s = i_q == 2'd0 ? i_y : (i_q == 2'd1 ? i_x : (i_q == 2'd2 ? -i_y : -i_x));
        o_c = sat(w_c);
        o_s = sat(w_s);
    end
endmodule

// File: rtl/cordic_nco_iter.sv
// cordic_nco_iter: iterative rotation-mode CORDIC sin/cos with amplitude scaling and NCO accumulator.
// Ports: clk, rst (sync, active-high), bus (slave side of cordic_nco_iter_if).
module cordic_nco_iter
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int AMP_WIDTH   = 16,
    parameter int ITER        = 16
) (
    input logic              clk,
    input logic              rst,
    cordic_nco_iter_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PHASE_WIDTH;
    localparam int AW = AMP_WIDTH;
    localparam logic signed [DW+1:0] K_INIT = (DW+2)'(k_init(DW));
    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t                 r_state, w_state_next;
    logic [PW-1:0]          r_acc;
    logic [1:0]             r_q;
    logic signed [DW+1:0]   r_x, r_y, w_xs, w_ys;
    logic signed [PW:0]     r_z, w_atan;
    logic [4:0]             r_iter;
    logic [AW-1:0]          r_amp;
    logic signed [DW-1:0]   r_c, r_s, w_c, w_s;
    logic signed [DW+AW-1:0] r_cos, r_sin, w_c_ext, w_s_ext, w_amp_ext;
    logic                   r_out_valid;
    logic                   w_accept;
    logic [PW-1:0]          w_angle;

    assign w_accept  = bus.in_valid && (r_state == IDLE);
    // NCO mode rotates by the accumulator value before the increment is added.
    assign w_angle   = !bus.in_mode ? bus.in_phase : (bus.phase_clr ? '0 : r_acc);
    assign w_atan    = (PW+1)'(ATAN_TABLE[r_iter] >> (32 - PW));
    assign w_xs      = r_x >>> r_iter;
    assign w_ys      = r_y >>> r_iter;
    assign w_c_ext   = {{AW{r_c[DW-1]}}, r_c};
    assign w_s_ext   = {{AW{r_s[DW-1]}}, r_s};
    assign w_amp_ext = {{DW{1'b0}}, r_amp};

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.cos_out   = r_cos;
    assign bus.sin_out   = r_sin;
    assign bus.phase_acc = r_acc;

    cordic_quadrant_sat #(.DATA_WIDTH(DW)) u_fold (
        .i_x(r_x),
        .i_y(r_y),
        .i_q(r_q),
        .o_c(w_c),
        .o_s(w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_accept ? ROTATE : IDLE;
            ROTATE:  w_state_next = (r_iter == LAST) ? FOLD : ROTATE;
            FOLD:    w_state_next = SCALE;
            SCALE:   w_state_next = HOLD;
            HOLD:    w_state_next = bus.out_ready ? IDLE : HOLD;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_cos       <= '0;
            r_sin       <= '0;
        end else begin
            r_acc <= (w_accept && bus.in_mode) ? (bus.phase_clr ? bus.in_phase : r_acc + bus.in_phase)
                   : (bus.phase_clr ? '0 : r_acc);
            if (w_accept) begin
                r_q    <= w_angle[PW-1 -: 2];
                r_z    <= $signed({3'b000, w_angle[PW-3:0]});
                r_x    <= K_INIT;
                r_y    <= '0;
                r_amp  <= bus.in_amp;
                r_iter <= '0;
            end
            if (r_state == ROTATE) begin
                r_x    <= r_z[PW] ? r_x + w_ys : r_x - w_ys;
                r_y    <= r_z[PW] ? r_y - w_xs : r_y + w_xs;
                r_z    <= r_z[PW] ? r_z + w_atan : r_z - w_atan;
                r_iter <= r_iter + 5'd1;
            end
            if (r_state == FOLD) begin
                r_c <= w_c;
                r_s <= w_s;
            end
            if (r_state == SCALE) begin
                r_cos       <= w_c_ext * w_amp_ext;
                r_sin       <= w_s_ext * w_amp_ext;
                r_out_valid <= 1'b1;
            end
            if (r_state == HOLD && bus.out_ready) r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cordic_nco_iter.sv
// tb_cordic_nco_iter: directed self-checking bench for cordic_nco_iter.
module tb_cordic_nco_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    cordic_nco_iter_if #(.DATA_WIDTH(16), .PHASE_WIDTH(16), .AMP_WIDTH(16)) bus ();

    cordic_nco_iter #(.DATA_WIDTH(16), .PHASE_WIDTH(16), .AMP_WIDTH(16), .ITER(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp, input longint tol);
        n_checks++;
        assert ((obs >= exp - tol && obs <= exp + tol) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic send(input string tag, input logic mode, input logic [15:0] ph,
                        input logic [15:0] amp, input logic clr);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_mode   = mode;
        bus.in_phase  = ph;
        bus.in_amp    = amp;
        bus.phase_clr = clr;
        tick();
        bus.in_valid  = 1'b0;
        bus.phase_clr = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_out_valid"}, longint'(bus.out_valid), 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic mode, input logic [15:0] ph, input logic [15:0] amp,
                       input logic clr, input longint exp_c, input longint exp_s, input longint tol,
                       input longint exp_acc);
        int lat;
        send(tag, mode, ph, amp, clr);
        check({tag, "_phase_acc"}, longint'(bus.phase_acc), exp_acc);
        wait_result(tag, lat);
        check_near({tag, "_cos"}, longint'(bus.cos_out), exp_c, tol);
        check_near({tag, "_sin"}, longint'(bus.sin_out), exp_s, tol);
        release_out();
    endtask

    initial begin
        int lat;
        int stale;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_phase  = '0;
        bus.in_amp    = '0;
        bus.phase_clr = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_cos", longint'(bus.cos_out), 0);
        check("rst_sin", longint'(bus.sin_out), 0);
        check("rst_phase_acc", longint'(bus.phase_acc), 0);
        rst = 1'b0;
        tick();

        send("lat0", 1'b0, 16'h0000, 16'd1, 1'b0);
        wait_result("lat0", lat);
        check("lat0_latency", longint'(lat), 18);
        check_near("lat0_cos", longint'(bus.cos_out), 32767, 4);
        check_near("lat0_sin", longint'(bus.sin_out), 0, 4);
        release_out();

        run("ang4000", 1'b0, 16'h4000, 16'd1, 1'b0, 0, 32767, 4, 0);
        run("ang2000", 1'b0, 16'h2000, 16'd1, 1'b0, 23170, 23170, 4, 0);
        run("ang8000", 1'b0, 16'h8000, 16'd1, 1'b0, -32767, 0, 4, 0);
        run("angC000", 1'b0, 16'hC000, 16'd1, 1'b0, 0, -32767, 4, 0);

        run("nco0", 1'b1, 16'h1000, 16'd1, 1'b0, 32767, 0, 4, 16'h1000);
        run("nco1", 1'b1, 16'h1000, 16'd1, 1'b0, 30273, 12539, 4, 16'h2000);
        run("nco2", 1'b1, 16'h1000, 16'd1, 1'b0, 23170, 23170, 4, 16'h3000);
        run("nco3", 1'b1, 16'h1000, 16'd1, 1'b0, 12539, 30273, 4, 16'h4000);
        run("nco4", 1'b1, 16'hB000, 16'd1, 1'b0, 0, 32767, 4, 16'hF000);
        run("nco_wrap", 1'b1, 16'hF000, 16'd1, 1'b0, 30273, -12539, 4, 16'hE000);
        run("nco_clr", 1'b1, 16'h1234, 16'd1, 1'b1, 32767, 0, 4, 16'h1234);

        bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        check("clr_alone_phase_acc", longint'(bus.phase_acc), 0);

        run("nco_pre", 1'b1, 16'h2000, 16'd1, 1'b0, 32767, 0, 4, 16'h2000);
        run("direct_clr", 1'b0, 16'h8000, 16'd1, 1'b1, -32767, 0, 4, 0);

        run("amp_max", 1'b0, 16'h2000, 16'hFFFF, 1'b0, longint'(23170) * 65535,
            longint'(23170) * 65535, longint'(4) * 65535, 0);
        run("amp_zero", 1'b0, 16'h2000, 16'h0000, 1'b0, 0, 0, 0, 0);

        send("bp", 1'b0, 16'h2000, 16'd1, 1'b0);
        wait_result("bp", lat);
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_phase = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", longint'(bus.out_valid), 1);
            check("bp_hold_in_ready", longint'(bus.in_ready), 0);
            check_near("bp_hold_cos", longint'(bus.cos_out), 23170, 4);
            check_near("bp_hold_sin", longint'(bus.sin_out), 23170, 4);
            tick();
        end
        check("bp_in_valid_ignored", longint'(bus.phase_acc), 0);
        bus.in_valid = 1'b0;
        release_out();
        check("bp_release_out_valid", longint'(bus.out_valid), 0);
        check("bp_release_in_ready", longint'(bus.in_ready), 1);

        send("rst_mid", 1'b1, 16'h0500, 16'd1, 1'b0);
        check("rst_mid_acc_before", longint'(bus.phase_acc), 16'h0500);
        repeat (4) tick();
        check("rst_mid_busy", longint'(bus.in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_in_ready", longint'(bus.in_ready), 1);
        check("rst_mid_out_valid", longint'(bus.out_valid), 0);
        check("rst_mid_phase_acc", longint'(bus.phase_acc), 0);
        check("rst_mid_cos", longint'(bus.cos_out), 0);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) stale++;
            tick();
        end
        check("rst_mid_no_stale", longint'(stale), 0);
        run("post_rst", 1'b0, 16'h0000, 16'd1, 1'b0, 32767, 0, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
